// File: rtl/tia_beam_sched.sv
// Beam scheduler for a TIA-style display: paces beam steps against an LCD sink and stalls the CPU on WSYNC.
// Optional completed-frame counter is enabled by defining TIA_SCHED_FRAME_CNT_EN.
module tia_beam_sched #(
    parameter int H_TOTAL  = 456,
    parameter int H_ACTIVE = 320,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240,
    parameter int V_TOP    = 24,
    parameter int V_BOT    = 226,
    parameter int PIX_GAP  = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wsync_i,
    input  logic       vsync_i,
    input  logic       lcd_busy_i,
    output logic [8:0] xpos_o,
    output logic [8:0] ypos_o,
    output logic       pix_req_o,
    output logic       pix_blank_o,
    output logic       reset_cursor_o,
    output logic       stall_cpu_o,
    output logic [7:0] frame_cnt_o
);

    localparam int GW = (PIX_GAP < 1) ? 1 : $clog2(PIX_GAP + 1);
    localparam logic [GW-1:0] GAP_MAX     = GW'(PIX_GAP);
    localparam logic [8:0]    X_LAST      = 9'(H_TOTAL - 1);
    localparam logic [8:0]    X_ACT_LAST  = 9'(H_ACTIVE - 1);
    localparam logic [8:0]    X_ACT       = 9'(H_ACTIVE);
    localparam logic [8:0]    Y_ACT       = 9'(V_ACTIVE);
    localparam logic [8:0]    Y_TOP       = 9'(V_TOP);
    localparam logic [8:0]    Y_BOT       = 9'(V_BOT);
    localparam logic [8:0]    Y_PARK_FROM = 9'(V_TOTAL - 2);
    localparam logic [8:0]    Y_PARKED    = 9'(V_TOTAL - 1);

    typedef enum logic {
        S_RUN,
        S_PARKED
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    xpos_q, xpos_d;
    logic [8:0]    ypos_q, ypos_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          adv_q, adv_d;
    logic          pix_req_q, pix_req_d;
    logic          pix_blank_q, pix_blank_d;
    logic          reset_cursor_q, reset_cursor_d;
    logic          stall_q, stall_d;
    logic          step_c;

    // adv_q is set the cycle after a step: coordinates stay at their pre-step
    // values alongside pix_req_o and move one cycle later.
    assign step_c = (state_q == S_RUN) && (gap_q == GAP_MAX) && !lcd_busy_i
                    && !pix_req_q && !adv_q && !vsync_i;

    always_comb begin
        state_d        = state_q;
        xpos_d         = xpos_q;
        ypos_d         = ypos_q;
        gap_d          = (gap_q < GAP_MAX) ? gap_q + GW'(1) : gap_q;
        adv_d          = 1'b0;
        pix_req_d      = 1'b0;
        pix_blank_d    = 1'b0;
        reset_cursor_d = 1'b0;
        stall_d        = stall_q;

        if (vsync_i) begin
            // vsync outranks everything, including a coincident wsync.
            state_d        = S_RUN;
            xpos_d         = 9'd0;
            ypos_d         = 9'd0;
            gap_d          = '0;
            reset_cursor_d = 1'b1;
            stall_d        = 1'b0;
        end else begin
            if (adv_q) begin
                if (xpos_q == X_LAST) begin
                    xpos_d = 9'd0;
                    if (ypos_q == Y_PARK_FROM) begin
                        ypos_d  = Y_PARKED;
                        state_d = S_PARKED;
                    end else begin
                        ypos_d = ypos_q + 9'd1;
                    end
                end else begin
                    xpos_d = xpos_q + 9'd1;
                end
            end

            if (step_c) begin
                gap_d       = '0;
                adv_d       = 1'b1;
                pix_req_d   = (xpos_q < X_ACT) && (ypos_q < Y_ACT);
                pix_blank_d = (ypos_q < Y_TOP) || (ypos_q >= Y_BOT);
                if (xpos_q == X_ACT_LAST) begin
                    stall_d = 1'b0;
                end
            end

            if (wsync_i) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_RUN;
            xpos_q         <= 9'd0;
            ypos_q         <= 9'd0;
            gap_q          <= '0;
            adv_q          <= 1'b0;
            pix_req_q      <= 1'b0;
            pix_blank_q    <= 1'b0;
            reset_cursor_q <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            xpos_q         <= xpos_d;
            ypos_q         <= ypos_d;
            gap_q          <= gap_d;
            adv_q          <= adv_d;
            pix_req_q      <= pix_req_d;
            pix_blank_q    <= pix_blank_d;
            reset_cursor_q <= reset_cursor_d;
            stall_q        <= stall_d;
        end
    end

    assign xpos_o         = xpos_q;
    assign ypos_o         = ypos_q;
    assign pix_req_o      = pix_req_q;
    assign pix_blank_o    = pix_blank_q;
    assign reset_cursor_o = reset_cursor_q;
    assign stall_cpu_o    = stall_q;

`ifdef TIA_SCHED_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vsync_i) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign frame_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_tia_beam_sched.sv
// Directed bench for tia_beam_sched on a shrunken raster (40x30 steps, PIX_GAP 8) so whole frames fit the budget.
module tb_tia_beam_sched;

    localparam int HT   = 40;
    localparam int HA   = 24;
    localparam int VT   = 30;
    localparam int VA   = 20;
    localparam int VTOP = 3;
    localparam int VBOT = 17;
    localparam int GAP  = 8;
    localparam int WAIT_MAX = 20000;
`ifdef TIA_SCHED_FRAME_CNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       wsync_i = 1'b0;
    logic       vsync_i = 1'b0;
    logic       lcd_busy_i = 1'b0;
    logic [8:0] xpos_o;
    logic [8:0] ypos_o;
    logic       pix_req_o;
    logic       pix_blank_o;
    logic       reset_cursor_o;
    logic       stall_cpu_o;
    logic [7:0] frame_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int npix    = 0;

    always #5 clk = ~clk;

    tia_beam_sched #(
        .H_TOTAL (HT),
        .H_ACTIVE(HA),
        .V_TOTAL (VT),
        .V_ACTIVE(VA),
        .V_TOP   (VTOP),
        .V_BOT   (VBOT),
        .PIX_GAP (GAP)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .wsync_i       (wsync_i),
        .vsync_i       (vsync_i),
        .lcd_busy_i    (lcd_busy_i),
        .xpos_o        (xpos_o),
        .ypos_o        (ypos_o),
        .pix_req_o     (pix_req_o),
        .pix_blank_o   (pix_blank_o),
        .reset_cursor_o(reset_cursor_o),
        .stall_cpu_o   (stall_cpu_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_pix(input int tx, input int ty, input string tag);
        int  cyc;
        bit  found;
        cyc   = 0;
        found = 0;
        while (!found && cyc < WAIT_MAX) begin
            @(negedge clk);
            cyc++;
            found = pix_req_o && (xpos_o == tx) && (ypos_o == ty);
        end
        if (!found) check(tag, 0, 1);
    endtask

    task automatic wait_xy(input int tx, input int ty, input string tag);
        int  cyc;
        bit  found;
        cyc   = 0;
        found = 0;
        while (!found && cyc < WAIT_MAX) begin
            @(negedge clk);
            cyc++;
            found = (xpos_o == tx) && (ypos_o == ty);
        end
        if (!found) check(tag, 0, 1);
    endtask

    task automatic pulse_wsync();
        wsync_i = 1'b1;
        @(negedge clk);
        wsync_i = 1'b0;
    endtask

    // Every pixel request must be inside the active window and carry the right blank flag.
    always @(negedge clk) begin
        if (rst_ni && pix_req_o) begin
            check("pix_blank", int'(pix_blank_o), int'((ypos_o < VTOP) || (ypos_o >= VBOT)));
            check("pix_active", int'((xpos_o < HA) && (ypos_o < VA)), 1);
            npix++;
        end
    end

    initial begin
        int cyc;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_x", xpos_o, 0);
        check("rst_y", ypos_o, 0);
        check("rst_pix", pix_req_o, 0);
        check("rst_blank", pix_blank_o, 0);
        check("rst_cursor", reset_cursor_o, 0);
        check("rst_stall", stall_cpu_o, 0);
        check("rst_frame", frame_cnt_o, 0);

        rst_ni = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pix_req_o && cyc < 100);
        check("first_pix_lat", cyc, GAP + 1);
        check("first_pix_x", xpos_o, 0);
        check("first_pix_y", ypos_o, 0);
        check("first_pix_blank", pix_blank_o, 1);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("adv_after_pix_x", xpos_o, 1);
                check("pix_one_cycle", pix_req_o, 0);
            end
        end while (!pix_req_o && cyc < 100);
        check("pix_period", cyc, GAP + 1);
        check("second_pix_x", xpos_o, 1);

        // Stall set mid-line and released by the last active step.
        wait_xy(10, 1, "to_x10_y1");
        pulse_wsync();
        check("stall_set_l1", stall_cpu_o, 1);
        wait_pix(HA - 2, 1, "to_pix22_l1");
        check("stall_hold_l1", stall_cpu_o, 1);
        wait_pix(HA - 1, 1, "to_pix23_l1");
        check("stall_clear_l1", stall_cpu_o, 0);

        // wsync landing on the clearing step keeps the stall.
        wait_xy(10, 2, "to_x10_y2");
        pulse_wsync();
        check("stall_set_l2", stall_cpu_o, 1);
        wait_pix(HA - 2, 2, "to_pix22_l2");
        repeat (GAP) @(negedge clk);
        pulse_wsync();
        check("clr_cycle_pix", pix_req_o, 1);
        check("clr_cycle_x", xpos_o, HA - 1);
        check("clr_cycle_stall", stall_cpu_o, 1);

        wait_pix(0, VTOP, "to_pix_top");
        check("top_blank", pix_blank_o, 0);
        check("stall_carried", stall_cpu_o, 1);
        wait_pix(HA - 1, VTOP, "to_pix23_l3");
        check("stall_clear_l3", stall_cpu_o, 0);

        // LCD busy holds the beam, release steps on the next clock.
        wait_xy(10, 4, "to_x10_y4");
        lcd_busy_i = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (pix_req_o) seen++;
        end
        check("busy_no_pix", seen, 0);
        check("busy_hold_x", xpos_o, 10);
        lcd_busy_i = 1'b0;
        @(negedge clk);
        check("busy_rel_pix", pix_req_o, 1);
        check("busy_rel_pix_x", xpos_o, 10);
        @(negedge clk);
        check("busy_rel_adv_x", xpos_o, 11);

        wait_pix(HA - 1, VBOT - 1, "to_pix_lastvis");
        check("lastvis_blank", pix_blank_o, 0);
        wait_pix(0, VBOT, "to_pix_bot");
        check("bot_blank", pix_blank_o, 1);

        // Frame end: parked on the last line with no further requests.
        wait_xy(0, VT - 1, "to_park");
        check("frame_pix_count", npix, HA * VA);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (pix_req_o) seen++;
        end
        check("park_no_pix", seen, 0);
        check("park_x", xpos_o, 0);
        check("park_y", ypos_o, VT - 1);
        pulse_wsync();
        check("park_stall_set", stall_cpu_o, 1);
        repeat (20) @(negedge clk);
        check("park_stall_hold", stall_cpu_o, 1);

        vsync_i = 1'b1;
        @(negedge clk);
        vsync_i = 1'b0;
        npix = 0;
        check("vs_cursor", reset_cursor_o, 1);
        check("vs_x", xpos_o, 0);
        check("vs_y", ypos_o, 0);
        check("vs_stall", stall_cpu_o, 0);
        check("vs_pix", pix_req_o, 0);
        check("vs_frame", frame_cnt_o, FC_EN * 1);
        @(negedge clk);
        check("vs_cursor_pulse", reset_cursor_o, 0);

        // Back-to-back vsync: each one restarts and pulses the cursor reset.
        vsync_i = 1'b1;
        @(negedge clk);
        check("vs2_cursor_a", reset_cursor_o, 1);
        @(negedge clk);
        check("vs2_cursor_b", reset_cursor_o, 1);
        vsync_i = 1'b0;
        check("vs2_frame", frame_cnt_o, FC_EN * 3);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pix_req_o && cyc < 100);
        check("vs_first_pix_lat", cyc, GAP + 1);
        check("vs_first_pix_x", xpos_o, 0);
        check("vs_first_pix_y", ypos_o, 0);

        // Asynchronous reset mid-frame while stalled.
        wait_xy(10, 5, "to_x10_y5");
        pulse_wsync();
        check("pre_rst_stall", stall_cpu_o, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_x", xpos_o, 0);
        check("arst_y", ypos_o, 0);
        check("arst_pix", pix_req_o, 0);
        check("arst_blank", pix_blank_o, 0);
        check("arst_cursor", reset_cursor_o, 0);
        check("arst_stall", stall_cpu_o, 0);
        check("arst_frame", frame_cnt_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tia_beam_sched.md
TIA_BEAM_SCHED -- requirements
Module: tia_beam_sched

Interface
REQ-001 Parameter H_TOTAL, default 456, beam steps per line (2 per color clock).
REQ-002 Parameter H_ACTIVE, default 320, visible steps per line.
REQ-003 Parameter V_TOTAL, default 262, lines per frame.
REQ-004 Parameter V_ACTIVE, default 240, lines sent to LCD.
REQ-005 Parameter V_TOP, default 24, first non-blanked line; V_BOT, default 226, first blanked bottom line.
REQ-006 Parameter PIX_GAP, default 8, minimum clocks between beam steps.
REQ-007 clk_i  input  1  single clock; all logic on rising edge.
REQ-008 rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 wsync_i  input  1  one-cycle pulse: CPU wrote WSYNC.
REQ-010 vsync_i  input  1  one-cycle pulse: CPU wrote VSYNC with D1 set.
REQ-011 lcd_busy_i  input  1  LCD driver busy; blocks beam steps.
REQ-012 xpos_o  output  9  current beam step in line.
REQ-013 ypos_o  output  9  current line.
REQ-014 pix_req_o  output  1  one-cycle pulse: drive pixel for current xpos_o/ypos_o.
REQ-015 pix_blank_o  output  1  valid with pix_req_o; 1 = send black (line <V_TOP or >=V_BOT).
REQ-016 reset_cursor_o  output  1  one-cycle pulse: LCD cursor to origin.
REQ-017 stall_cpu_o  output  1  CPU halted awaiting horizontal blank.
REQ-018 frame_cnt_o  output  8  completed-frame count (see Configuration).

Function
REQ-019 States: RUN (beam advancing) and PARKED (frame done, waiting for vsync_i).
REQ-020 gap counter increments each clock while below PIX_GAP, saturating at PIX_GAP.
REQ-021 Step condition: RUN, gap==PIX_GAP, !lcd_busy_i, pix_req_o low this cycle, no vsync_i.
REQ-022 On step: pix_req_o=1 next cycle iff xpos_o<H_ACTIVE and ypos_o<V_ACTIVE (pre-step values); gap cleared to 0.
REQ-023 On step: xpos_o increments; at xpos_o==H_TOTAL-1 wraps to 0, ypos_o increments.
REQ-024 Step from xpos_o==H_TOTAL-1 with ypos_o==V_TOTAL-2 enters PARKED; ypos_o holds V_TOTAL-1, xpos_o 0; no further steps.
REQ-025 pix_req_o registered with the coordinates it refers to (pre-step values held on pix-side outputs) — xpos_o/ypos_o update one cycle after pix_req_o deasserts is NOT allowed; implementation SHALL present pre-step coordinates on xpos_o/ypos_o during the pix_req_o cycle and advance them the following cycle.
REQ-026 wsync_i sets stall_cpu_o next cycle.
REQ-027 stall_cpu_o clears on the step moving xpos_o from H_ACTIVE-1 to H_ACTIVE, or on vsync_i.
REQ-028 wsync_i coincident with a clear event: set wins, stall_cpu_o=1.
REQ-029 wsync_i in PARKED: stall holds until vsync_i.
REQ-030 vsync_i (any state, highest priority): next cycle xpos_o=0, ypos_o=0, gap=0, state RUN, stall_cpu_o=0, reset_cursor_o=1 for one cycle, no pix_req_o.
REQ-031 Consecutive vsync_i pulses: each restarts; reset_cursor_o pulses each time.
REQ-032 lcd_busy_i asserting mid-gap only delays the step; gap keeps saturating.

Reset
REQ-033 rst_ni low: xpos_o=0, ypos_o=0, gap=0, state RUN, pix_req_o=0, pix_blank_o=0, reset_cursor_o=0, stall_cpu_o=0, frame_cnt_o=0.
REQ-034 Reset mid-frame or mid-stall aborts immediately; first step no earlier than PIX_GAP+1 clocks after rst_ni rises.

Configuration
REQ-035 Macro TIA_SCHED_FRAME_CNT_EN: defined -> frame_cnt_o increments (mod 256) on each vsync_i; undefined -> frame_cnt_o constant 0, no counter logic.

Verification
REQ-036 Reset, lcd_busy_i=0, defaults -> first pix_req_o at (0,0) with pix_blank_o=1; pulses every 9 clocks.
REQ-037 Run to line 24 -> pix_req_o with pix_blank_o=0 at ypos_o=24; blank again at ypos_o=226; no pix_req_o for xpos_o>=320 or ypos_o>=240.
REQ-038 wsync_i at xpos_o=100 -> stall_cpu_o=1 until step 319->320; wsync_i on that clear cycle -> stall stays 1.
REQ-039 Free run with no vsync_i -> PARKED at ypos_o=261, pix_req_o silent; vsync_i -> reset_cursor_o pulse, (0,0), frame_cnt_o=1 with macro, 0 without.
REQ-040 Hold lcd_busy_i=1 for 50 clocks at xpos_o=10 -> no step; release -> step next eligible clock, xpos_o=11.
REQ-041 Drop rst_ni at ypos_o=100 with stall_cpu_o=1 -> all outputs zero asynchronously.
